// File: rtl/jk_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jk_counter_pkg
//  Purpose  : Shared constants for the JK-flip-flop synchronous counter:
//             JK excitation encodings, default counter width and the
//             direction encodings of the UP input.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package jk_counter_pkg;

  // Default counter width; legal range is 2..16.
  localparam int DEFAULT_WIDTH = 4;

  // JK excitation encodings, written as {J, K}.
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  // Values of the UP input.
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage
`default_nettype wire

// File: rtl/jk_ff_sync.sv
`default_nettype none
// ============================================================================
//  Module   : jk_ff_sync
//  Purpose  : Single rising-edge JK flip-flop with synchronous active-low
//             clear. {J,K}: 00 hold, 01 reset, 10 set, 11 toggle.
//  Ports    : CLK   - clock, rising edge active
//             CLR_N - synchronous clear, active low (wins over J/K)
//             J, K  - excitation inputs
//             Q     - stored bit
//             Q_not - complement of Q
//  Revision : 1.0 - initial release
// ============================================================================
module jk_ff_sync
  import jk_counter_pkg::*;
(
  input  logic CLK,
  input  logic CLR_N,
  input  logic J,
  input  logic K,
  output logic Q,
  output logic Q_not
);

  logic r_q;

  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      r_q <= 1'b0;
    end else begin
      case ({J, K})
        JK_HOLD: r_q <= r_q;
        JK_RST:  r_q <= 1'b0;
        JK_SET:  r_q <= 1'b1;
        JK_TGL:  r_q <= ~r_q;
        default: r_q <= r_q;
      endcase
    end
  end

  assign Q     = r_q;
  assign Q_not = ~r_q;

endmodule
`default_nettype wire

// File: rtl/jk_sync_counter.sv
`default_nettype none
// ============================================================================
//  Module   : jk_sync_counter
//  Purpose  : Synchronous up/down modulo counter (sequence 0..MOD) built from
//             one JK flip-flop per bit, with parallel load, a combinational
//             terminal-count flag and a registered one-cycle wrap pulse.
//             Priority per edge: clear > load > count > hold.
//  Ports    : CLK   - clock, rising edge active
//             CLR_N - synchronous clear, active low
//             EN    - count enable
//             UP    - direction (1 up, 0 down)
//             LOAD  - parallel load strobe
//             D     - parallel load value
//             terminal count - input port named MOD
//             Q     - current count
//             Q_not - bitwise complement of Q
//             TC    - combinational terminal-count indication
//             WRAP  - registered pulse, high the cycle after a wrap
//  Revision : 1.0 - initial release
// ============================================================================
module jk_sync_counter
  import jk_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic             EN,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] MOD,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_not,
  output logic             TC,
  output logic             WRAP
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_q_not;
  logic [WIDTH-1:0] w_up_tgl;
  logic [WIDTH-1:0] w_dn_tgl;
  logic [WIDTH-1:0] w_toggle;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic             w_at_top;
  logic             w_at_zero;
  logic             w_tc;
  logic             w_jam;
  logic             r_wrap;

  // ">=" rather than "==" so a count loaded above MOD wraps to 0 when
  // counting up instead of running on to 2^WIDTH.
  assign w_at_top  = (w_q >= MOD);
  assign w_at_zero = (w_q == '0);

  assign w_tc = EN & ~LOAD &
                (((UP == DIR_UP) & w_at_top) | ((UP == DIR_DN) & w_at_zero));

  // Any edge whose next value is not a plain +/-1 step: the new value is
  // forced bit-by-bit with J=next, K=~next.
  assign w_jam = ~CLR_N | LOAD | w_tc;

  // Ripple-free toggle conditions: bit i toggles when all lower bits are 1
  // (counting up) or all lower bits are 0 (counting down).
  always_comb begin
    w_up_tgl    = '0;
    w_dn_tgl    = '0;
    w_up_tgl[0] = 1'b1;
    w_dn_tgl[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      w_up_tgl[i] = w_up_tgl[i-1] & w_q[i-1];
      w_dn_tgl[i] = w_dn_tgl[i-1] & w_q_not[i-1];
    end
  end

  assign w_toggle = (UP == DIR_UP) ? w_up_tgl : w_dn_tgl;

  // Forced next value; only meaningful while w_jam is high. When neither
  // clear nor load is active, w_jam implies a wrap: up wraps to 0, down to MOD.
  always_comb begin
    w_next = '0;
    if (!CLR_N) begin
      w_next = '0;
    end else if (LOAD) begin
      w_next = D;
    end else if (UP == DIR_UP) begin
      w_next = '0;
    end else begin
      w_next = MOD;
    end
  end

  always_comb begin
    w_j = '0;
    w_k = '0;
    if (w_jam) begin
      w_j = w_next;
      w_k = ~w_next;
    end else if (EN) begin
      w_j = w_toggle;
      w_k = w_toggle;
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      jk_ff_sync u_ff (
        .CLK   (CLK),
        .CLR_N (CLR_N),
        .J     (w_j[gi]),
        .K     (w_k[gi]),
        .Q     (w_q[gi]),
        .Q_not (w_q_not[gi])
      );
    end
  endgenerate

  // A wrap happens exactly on edges where TC is high and clear is released.
  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_tc;
    end
  end

  assign Q     = w_q;
  assign Q_not = w_q_not;
  assign TC    = w_tc;
  assign WRAP  = r_wrap;

endmodule
`default_nettype wire
